// File: rtl/instr_fetch_if.sv
// Fetch-unit bus bundle: ROM address/data plus the IF/ID decode-side signals.
// FETCH_COUNT_EN adds the fetch_count observation port.
interface instr_fetch_if #(
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] rom_addr;
  logic [31:0]       rom_instr;
  logic              stall;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic              if_valid;
  logic [31:0]       if_instr;
  logic [31:0]       if_pc;
  logic              fault;
  logic [31:0]       fault_pc;
`ifdef FETCH_COUNT_EN
  logic [31:0]       fetch_count;

  modport master (
    output rom_addr, if_valid, if_instr, if_pc, fault, fault_pc, fetch_count,
    input  rom_instr, stall, redirect_valid, redirect_pc
  );
  modport slave (
    input  rom_addr, if_valid, if_instr, if_pc, fault, fault_pc, fetch_count,
    output rom_instr, stall, redirect_valid, redirect_pc
  );
`else
  modport master (
    output rom_addr, if_valid, if_instr, if_pc, fault, fault_pc,
    input  rom_instr, stall, redirect_valid, redirect_pc
  );
  modport slave (
    input  rom_addr, if_valid, if_instr, if_pc, fault, fault_pc,
    output rom_instr, stall, redirect_valid, redirect_pc
  );
`endif
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: PC, ROM addressing, IF/ID register, redirect/stall, sticky fault.
// Optional FETCH_COUNT_EN adds a 32-bit fetch counter on the bus.
module instr_fetch #(
  parameter int          ADDR_W   = 5,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic            clk,
  input logic            rst_n,
  instr_fetch_if.master  bus
);

  typedef enum logic [1:0] {IDLE, RUN, FAULT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        vld_q, vld_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ipc_q, ipc_d;
  logic        fault_q, fault_d;
  logic [31:0] fpc_q, fpc_d;
  logic        fetch;
  logic        pc_bad;

  // Legal PCs are word-aligned and inside the 2^ADDR_W-word ROM.
  assign pc_bad = (pc_q[1:0] != 2'b00) || (pc_q[31:ADDR_W+2] != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      vld_q   <= 1'b0;
      instr_q <= '0;
      ipc_q   <= '0;
      fault_q <= 1'b0;
      fpc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      vld_q   <= vld_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      fault_q <= fault_d;
      fpc_q   <= fpc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    vld_d   = vld_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    fault_d = fault_q;
    fpc_d   = fpc_q;
    fetch   = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = RUN;
        vld_d   = 1'b0;
        if (bus.redirect_valid) pc_d = bus.redirect_pc;
      end
      RUN: begin
        if (bus.redirect_valid) begin
          // Wrong-path word is dropped; alignment is checked only when fetching.
          pc_d  = bus.redirect_pc;
          vld_d = 1'b0;
        end else if (bus.stall) begin
          // hold everything
        end else if (pc_bad) begin
          state_d = FAULT;
          fault_d = 1'b1;
          fpc_d   = pc_q;
          vld_d   = 1'b0;
        end else begin
          fetch   = 1'b1;
          instr_d = bus.rom_instr;
          ipc_d   = pc_q;
          vld_d   = 1'b1;
          pc_d    = pc_q + 32'd4;
        end
      end
      FAULT: begin
        vld_d = 1'b0;
      end
      default: begin
        state_d = FAULT;
        vld_d   = 1'b0;
      end
    endcase
  end

`ifdef FETCH_COUNT_EN
  logic [31:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     cnt_q <= '0;
    else if (fetch) cnt_q <= cnt_q + 32'd1;
  end

  assign bus.fetch_count = cnt_q;
`else
  logic unused_fetch;
  assign unused_fetch = fetch;
`endif

  assign bus.rom_addr = pc_q[ADDR_W+1:2];
  assign bus.if_valid = vld_q;
  assign bus.if_instr = instr_q;
  assign bus.if_pc    = ipc_q;
  assign bus.fault    = fault_q;
  assign bus.fault_pc = fpc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: cycle table for fetch/stall/redirect, then
// hand sequences for misaligned fault, end-of-ROM fault and mid-run reset.
module tb_instr_fetch;

  localparam int ADDR_W = 5;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic [31:0] rom [32];

  instr_fetch_if #(.ADDR_W(ADDR_W)) bus ();

  instr_fetch #(.ADDR_W(ADDR_W), .RESET_PC(32'h0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.rom_instr = rom[bus.rom_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        rv;
    logic [31:0] rpc;
    logic        e_vld;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [4:0]  e_addr;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic rv, input logic [31:0] rpc);
    bus.stall          = s;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 32'h0);
    step();
    rst_n = 1'b1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " if_valid"}, {31'h0, bus.if_valid}, 32'h0);
    chk({tag, " if_instr"}, bus.if_instr, 32'h0);
    chk({tag, " if_pc"},    bus.if_pc, 32'h0);
    chk({tag, " fault"},    {31'h0, bus.fault}, 32'h0);
    chk({tag, " fault_pc"}, bus.fault_pc, 32'h0);
    chk({tag, " rom_addr"}, {27'h0, bus.rom_addr}, 32'h0);
`ifdef FETCH_COUNT_EN
    chk({tag, " fetch_count"}, bus.fetch_count, 32'h0);
`endif
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 32; i++) rom[i] = 32'h1000_0000 | i;
    rom[0]  = 32'h2401_0001;
    rom[1]  = 32'h2402_0002;
    rom[2]  = 32'h0041_1821;
    rom[9]  = 32'h8d8c_fffc;
    rom[31] = 32'h8c0a_0008;

    //          stall rv   rpc      vld   if_pc    if_instr        addr
    tbl[0] = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h00, 32'h0000_0000, 5'd0};
    tbl[1] = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h00, 32'h2401_0001, 5'd1};
    tbl[2] = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h04, 32'h2402_0002, 5'd2};
    tbl[3] = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h04, 32'h2402_0002, 5'd2};
    tbl[4] = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h04, 32'h2402_0002, 5'd2};
    tbl[5] = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h04, 32'h2402_0002, 5'd2};
    tbl[6] = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h08, 32'h0041_1821, 5'd3};
    tbl[7] = '{1'b1, 1'b1, 32'h24, 1'b0, 32'h08, 32'h0041_1821, 5'd9};
    tbl[8] = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h24, 32'h8d8c_fffc, 5'd10};
    tbl[9] = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h28, 32'h1000_000a, 5'd11};

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 32'h0);
    #3;
    chk_zero("reset");
    do_reset();

    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].stall, tbl[i].rv, tbl[i].rpc);
      step();
      chk($sformatf("row%0d if_valid", i), {31'h0, bus.if_valid}, {31'h0, tbl[i].e_vld});
      chk($sformatf("row%0d if_pc", i), bus.if_pc, tbl[i].e_pc);
      chk($sformatf("row%0d if_instr", i), bus.if_instr, tbl[i].e_instr);
      chk($sformatf("row%0d rom_addr", i), {27'h0, bus.rom_addr}, {27'h0, tbl[i].e_addr});
      chk($sformatf("row%0d fault", i), {31'h0, bus.fault}, 32'h0);
    end

    // Misaligned redirect: bubble, then sticky fault that ignores redirect/stall.
    drive(1'b0, 1'b1, 32'h1e);
    step();
    chk("mis bubble vld", {31'h0, bus.if_valid}, 32'h0);
    chk("mis bubble fault", {31'h0, bus.fault}, 32'h0);
    drive(1'b0, 1'b0, 32'h0);
    step();
    chk("mis fault", {31'h0, bus.fault}, 32'h1);
    chk("mis fault_pc", bus.fault_pc, 32'h1e);
    chk("mis vld", {31'h0, bus.if_valid}, 32'h0);
    drive(1'b1, 1'b1, 32'h0);
    step();
    drive(1'b0, 1'b0, 32'h0);
    step();
    chk("sticky fault", {31'h0, bus.fault}, 32'h1);
    chk("sticky fault_pc", bus.fault_pc, 32'h1e);
    chk("sticky vld", {31'h0, bus.if_valid}, 32'h0);
    chk("sticky rom_addr", {27'h0, bus.rom_addr}, 32'h7);

    // End of ROM, entered via a redirect accepted in IDLE; stall delays the fault.
    do_reset();
    chk_zero("reset2");
    drive(1'b0, 1'b1, 32'h78);
    step();
    chk("idle vld", {31'h0, bus.if_valid}, 32'h0);
    drive(1'b0, 1'b0, 32'h0);
    step();
    chk("eor pc78", bus.if_pc, 32'h78);
    chk("eor instr78", bus.if_instr, 32'h1000_001e);
    step();
    chk("eor pc7c", bus.if_pc, 32'h7c);
    chk("eor instr7c", bus.if_instr, 32'h8c0a_0008);
    chk("eor vld7c", {31'h0, bus.if_valid}, 32'h1);
    drive(1'b1, 1'b0, 32'h0);
    step();
    chk("eor stall nofault", {31'h0, bus.fault}, 32'h0);
    chk("eor stall vld", {31'h0, bus.if_valid}, 32'h1);
    chk("eor stall pc", bus.if_pc, 32'h7c);
    drive(1'b0, 1'b0, 32'h0);
    step();
    chk("eor fault", {31'h0, bus.fault}, 32'h1);
    chk("eor fault_pc", bus.fault_pc, 32'h80);
    chk("eor vld", {31'h0, bus.if_valid}, 32'h0);

    // Mid-run asynchronous reset at if_pc=0x10, then restart.
    do_reset();
    step();
    for (int i = 0; i < 5; i++) step();
    chk("run pc10", bus.if_pc, 32'h10);
`ifdef FETCH_COUNT_EN
    chk("run count5", bus.fetch_count, 32'd5);
`endif
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("async");
    step();
    rst_n = 1'b1;
    step();
    chk("restart idle vld", {31'h0, bus.if_valid}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("restart pc%0d", i), bus.if_pc, 32'(i * 4));
      chk($sformatf("restart instr%0d", i), bus.if_instr, rom[i]);
`ifdef FETCH_COUNT_EN
      chk($sformatf("restart count%0d", i), bus.fetch_count, 32'(i + 1));
`endif
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
